mem_bank_2rw_arb_80: RTL

// - Shares one 32x80 two-port (RW0/RW1) byte-masked memory bank between NREQ requesters.
// - Grants up to two requests per cycle (one per port), round-robin fair, and never issues two conflicting same-address accesses.
// - Registers read data back to requesters; optionally zero-fills the bank after reset.

---
 rtl/mem_bank_arb_pkg.sv | 14 +
 rtl/mem_bank_2rw_arb_80_if.sv | 16 +
 rtl/mem_bank_rr_pick2.sv | 38 +++
 rtl/mem_bank_2rw_arb_80.sv | 126 ++++++++++++
 4 files changed

// File: rtl/mem_bank_arb_pkg.sv
// mem_bank_arb_pkg: shared constants, FSM states and request record for the 2RW bank arbiter
package mem_bank_arb_pkg;
  localparam int AW = 5;
  localparam int DW = 80;
  localparam int NB = DW / 8;
  localparam int IDW = 3;
  typedef enum logic {ST_INIT, ST_RUN} state_e;
  typedef struct packed {
    logic wmode;
    logic [AW-1:0] addr;
    logic [NB-1:0] bmask;
    logic [DW-1:0] wdata;
  } req_t;
endpackage

// File: rtl/mem_bank_2rw_arb_80_if.sv
// mem_bank_2rw_arb_80_if: requester request/response bus of the 2RW bank arbiter
// Ports (signals): req_valid/req_ready/req_wmode per requester; req_addr/req_bmask/req_wdata packed per requester;
//   rsp_valid/rsp_id/rsp_rdata per bank port lane. master = requesters, slave = arbiter.
interface mem_bank_2rw_arb_80_if import mem_bank_arb_pkg::*; #(parameter int NREQ = 4);
  logic [NREQ-1:0] req_valid, req_ready, req_wmode;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*NB-1:0] req_bmask;
  logic [NREQ*DW-1:0] req_wdata;
  logic [1:0] rsp_valid;
  logic [2*IDW-1:0] rsp_id;
  logic [2*DW-1:0] rsp_rdata;
  modport master (output req_valid, req_wmode, req_addr, req_bmask, req_wdata,
                  input req_ready, rsp_valid, rsp_id, rsp_rdata);
  modport slave (input req_valid, req_wmode, req_addr, req_bmask, req_wdata,
                 output req_ready, rsp_valid, rsp_id, rsp_rdata);
endinterface

// File: rtl/mem_bank_rr_pick2.sv
// mem_bank_rr_pick2: combinational two-winner round-robin picker with same-address conflict skip
// Ports: i_valid/i_wmode/i_addr per requester, i_ptr scan start; o_g0/o_id0 winner for RW0, o_g1/o_id1 winner for RW1.
module mem_bank_rr_pick2 import mem_bank_arb_pkg::*; #(parameter int NREQ = 4) (
  input  logic [NREQ-1:0]         i_valid,
  input  logic [NREQ-1:0]         i_wmode,
  input  logic [NREQ-1:0][AW-1:0] i_addr,
  input  logic [IDW-1:0]          i_ptr,
  output logic                    o_g0,
  output logic                    o_g1,
  output logic [IDW-1:0]          o_id0,
  output logic [IDW-1:0]          o_id1
);
  logic [AW-1:0] w_a0;
  logic w_w0;
  // pass 0 scans ptr..NREQ-1, pass 1 wraps over 0..ptr-1; a later candidate touching the
  // first winner's address is skipped unless both are reads
  always_comb begin
    o_g0 = 1'b0;
    o_g1 = 1'b0;
    o_id0 = '0;
    o_id1 = '0;
    w_a0 = '0;
    w_w0 = 1'b0;
    for (int p = 0; p < 2; p++)
      for (int j = 0; j < NREQ; j++)
        if (((p == 0) == (IDW'(j) >= i_ptr)) && i_valid[j]) begin
          if (!o_g0) begin
            o_g0 = 1'b1;
            o_id0 = IDW'(j);
            w_a0 = i_addr[j];
            w_w0 = i_wmode[j];
          end else if (!o_g1 && !(i_addr[j] == w_a0 && (i_wmode[j] || w_w0))) begin
            o_g1 = 1'b1;
            o_id1 = IDW'(j);
          end
        end
  end
endmodule

// File: rtl/mem_bank_2rw_arb_80.sv
// mem_bank_2rw_arb_80: shares one 32x80 two-port byte-masked bank between NREQ requesters
// Ports: i_clock, i_reset (sync, active-high); bus (slave modport) request/response bus;
//   o_init_done bank usable; o_rwP_* / i_rwP_rdata drive bank ports RW0/RW1 (o_rwP_clk = i_clock).
// Option: MEM_BANK_ARB_INIT_EN zero-fills the bank (two addresses per cycle) after reset.
module mem_bank_2rw_arb_80 import mem_bank_arb_pkg::*; #(parameter int NREQ = 4) (
  input  logic          i_clock,
  input  logic          i_reset,
  mem_bank_2rw_arb_80_if.slave bus,
  output logic          o_init_done,
  output logic          o_rw0_clk,
  output logic          o_rw0_en,
  output logic          o_rw0_wmode,
  output logic [AW-1:0] o_rw0_addr,
  output logic [DW-1:0] o_rw0_wmask,
  output logic [DW-1:0] o_rw0_wdata,
  input  logic [DW-1:0] i_rw0_rdata,
  output logic          o_rw1_clk,
  output logic          o_rw1_en,
  output logic          o_rw1_wmode,
  output logic [AW-1:0] o_rw1_addr,
  output logic [DW-1:0] o_rw1_wmask,
  output logic [DW-1:0] o_rw1_wdata,
  input  logic [DW-1:0] i_rw1_rdata
);
`ifdef MEM_BANK_ARB_INIT_EN
  localparam state_e RST_ST = ST_INIT;
`else
  localparam state_e RST_ST = ST_RUN;
`endif
  req_t [NREQ-1:0] w_req;
  logic [NREQ-1:0][AW-1:0] w_av;
  state_e r_state, w_state;
  logic [AW-2:0] r_init_addr;
  logic [IDW-1:0] r_ptr, w_id0, w_id1, w_last;
  logic [1:0][IDW-1:0] w_id, r_rsp_id;
  logic [1:0] w_g, w_en, w_wm, r_rsp_valid;
  logic [1:0][AW-1:0] w_pa;
  logic [1:0][DW-1:0] w_pm, w_pd, w_rd, r_rsp_rdata;
  logic w_g0, w_g1, w_run, r_init_done;
  for (genvar g = 0; g < NREQ; g++) begin : g_unpack
    assign w_req[g] = {bus.req_wmode[g], bus.req_addr[g*AW +: AW], bus.req_bmask[g*NB +: NB], bus.req_wdata[g*DW +: DW]};
    assign w_av[g] = w_req[g].addr;
  end
  assign w_run = r_init_done && !i_reset;
  mem_bank_rr_pick2 #(.NREQ(NREQ)) u_pick (
    .i_valid(bus.req_valid & {NREQ{w_run}}),
    .i_wmode(bus.req_wmode),
    .i_addr(w_av),
    .i_ptr(r_ptr),
    .o_g0(w_g0),
    .o_g1(w_g1),
    .o_id0(w_id0),
    .o_id1(w_id1)
  );
  assign w_g = {w_g1, w_g0};
  assign w_id = {w_id1, w_id0};
  assign w_last = w_g1 ? w_id1 : w_id0;
  assign w_rd = {i_rw1_rdata, i_rw0_rdata};
  assign w_state = i_reset ? RST_ST : (r_state == ST_INIT && &r_init_addr) ? ST_RUN : r_state;
  always_comb begin
    bus.req_ready = '0;
    for (int j = 0; j < NREQ; j++)
      bus.req_ready[j] = (w_g0 && w_id0 == IDW'(j)) || (w_g1 && w_id1 == IDW'(j));
  end
  // INIT zero-fills even/odd address pairs; RUN routes each winner's fields onto its port
  always_comb begin
    w_en = '0;
    w_wm = '0;
    w_pa = '0;
    w_pm = '0;
    w_pd = '0;
    for (int p = 0; p < 2; p++)
      if (r_state == ST_INIT && !i_reset) begin
        w_en[p] = 1'b1;
        w_wm[p] = 1'b1;
        w_pa[p] = {r_init_addr, 1'(p)};
        w_pm[p] = DW'({NB{1'b1}});
      end else
        for (int j = 0; j < NREQ; j++)
          if (w_g[p] && w_id[p] == IDW'(j)) begin
            w_en[p] = 1'b1;
            w_wm[p] = w_req[j].wmode;
            w_pa[p] = w_req[j].addr;
            w_pm[p] = DW'(w_req[j].bmask);
            w_pd[p] = w_req[j].wdata;
          end
  end
  always_ff @(posedge i_clock) begin
    r_state <= w_state;
    r_init_done <= !i_reset && w_state == ST_RUN;
    if (i_reset) begin
      r_init_addr <= '0;
      r_ptr <= '0;
      r_rsp_valid <= '0;
      r_rsp_id <= '0;
      r_rsp_rdata <= '0;
    end else begin
      if (r_state == ST_INIT) r_init_addr <= r_init_addr + 1'b1;
      if (w_g0) r_ptr <= (w_last == IDW'(NREQ - 1)) ? '0 : w_last + 1'b1;
      for (int p = 0; p < 2; p++) begin
        r_rsp_valid[p] <= w_en[p] && !w_wm[p];
        if (w_en[p] && !w_wm[p]) begin
          r_rsp_id[p] <= w_id[p];
          r_rsp_rdata[p] <= w_rd[p];
        end
      end
    end
  end
  // a response still registered when reset arrives is never presented
  assign bus.rsp_valid = r_rsp_valid & {2{!i_reset}};
  assign bus.rsp_id = r_rsp_id;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign o_init_done = r_init_done;
  assign o_rw0_clk = i_clock;
  assign o_rw0_en = w_en[0];
  assign o_rw0_wmode = w_wm[0];
  assign o_rw0_addr = w_pa[0];
  assign o_rw0_wmask = w_pm[0];
  assign o_rw0_wdata = w_pd[0];
  assign o_rw1_clk = i_clock;
  assign o_rw1_en = w_en[1];
  assign o_rw1_wmode = w_wm[1];
  assign o_rw1_addr = w_pa[1];
  assign o_rw1_wmask = w_pm[1];
  assign o_rw1_wdata = w_pd[1];
endmodule
